// File: rtl/rotary_multi_ctrl.sv
// rotary_multi_ctrl: multi-channel rotary-joystick emulator for the SNK68 core.
// Converts per-channel cw/ccw button levels into one-hot rotary positions.
// A button held down auto-repeats after a programmable delay, at a programmable rate.
// Optional macro ROTARY_ABS_EN adds the absolute-target seek inputs abs_valid/abs_target.
//
// state  | meaning
// IDLE   | no direction held; in ROTARY_ABS_EN builds the channel may seek its target here
// HOLD   | direction held, waiting REPEAT_DELAY_MS ticks before the first repeat step
// REPEAT | direction held, stepping every REPEAT_RATE_MS ticks
module rotary_multi_ctrl #(
  parameter int CHANNELS        = 2,
  parameter int POSITIONS       = 12,
  parameter int RESET_POS       = 0,
  parameter int CLK_HZ          = 72000000,
  parameter int REPEAT_DELAY_MS = 250,
  parameter int REPEAT_RATE_MS  = 50,
  parameter int IDXW            = $clog2(POSITIONS)
) (
  input  logic                          clk_72,
  input  logic                          reset,
  input  logic [CHANNELS-1:0]           cw,
  input  logic [CHANNELS-1:0]           ccw,
`ifdef ROTARY_ABS_EN
  input  logic [CHANNELS-1:0]           abs_valid,
  input  logic [CHANNELS*IDXW-1:0]      abs_target,
`endif
  output logic [CHANNELS*POSITIONS-1:0] rotary,
  output logic [CHANNELS*IDXW-1:0]      pos_idx,
  output logic [CHANNELS-1:0]           step_pulse
);

  localparam int TICK_PERIOD = (CLK_HZ / 1000 < 1) ? 1 : CLK_HZ / 1000;
  localparam int PW          = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
  localparam int MAXMS       = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ? REPEAT_DELAY_MS : REPEAT_RATE_MS;
  localparam int CNTW        = $clog2(MAXMS + 2);
  localparam logic [POSITIONS-1:0] RESET_ONEHOT = POSITIONS'(1) << RESET_POS;

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

  logic [PW-1:0]                  presc_q, presc_d;
  logic                           ms_tick;
  state_t                         state_q [CHANNELS];
  state_t                         state_d [CHANNELS];
  logic [CNTW-1:0]                cnt_q   [CHANNELS];
  logic [CNTW-1:0]                cnt_d   [CHANNELS];
  logic [1:0]                     last_q  [CHANNELS];
  logic [1:0]                     last_d  [CHANNELS];
  logic [CHANNELS*IDXW-1:0]       pos_idx_q, pos_idx_d;
  logic [CHANNELS*POSITIONS-1:0]  rotary_q, rotary_d;
  logic [CHANNELS-1:0]            step_pulse_q, step_pulse_d;

  function automatic logic [IDXW-1:0] idx_inc(input logic [IDXW-1:0] i);
    if (i == IDXW'(POSITIONS - 1)) return '0;
    return i + 1'b1;
  endfunction

  function automatic logic [IDXW-1:0] idx_dec(input logic [IDXW-1:0] i);
    if (i == '0) return IDXW'(POSITIONS - 1);
    return i - 1'b1;
  endfunction

  // Shared ms prescaler: tick for one cycle when the counter wraps.
  always_comb begin
    ms_tick = (presc_q == PW'(TICK_PERIOD - 1));
    presc_d = ms_tick ? '0 : presc_q + 1'b1;
  end

  // Per-channel next-state: direction decode, press detect, hold/repeat timing, step.
  always_comb begin
    logic [1:0]      dir;        // bit0 = CW, bit1 = CCW, 0 = NEUTRAL
    logic            press;
    logic [CNTW-1:0] cnt_t;      // count after this cycle's tick, saturating
    logic            step_cw, step_ccw;
    logic [IDXW-1:0] idx;
`ifdef ROTARY_ABS_EN
    logic [IDXW-1:0] tgt;
    int              ccw_dist;
`endif
    pos_idx_d    = pos_idx_q;
    rotary_d     = rotary_q;
    step_pulse_d = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      dir      = {ccw[c] & ~cw[c], cw[c] & ~ccw[c]};
      press    = (dir != 2'b00) && (dir != last_q[c]);
      cnt_t    = cnt_q[c];
      if (ms_tick && (cnt_q[c] != '1)) cnt_t = cnt_q[c] + 1'b1;
      step_cw  = 1'b0;
      step_ccw = 1'b0;
      idx      = pos_idx_q[c*IDXW +: IDXW];
      state_d[c] = state_q[c];
      cnt_d[c]   = cnt_q[c];
      last_d[c]  = dir;
      if (press) begin
        step_cw    = dir[0];
        step_ccw   = dir[1];
        cnt_d[c]   = '0;
        state_d[c] = HOLD;
      end else begin
        case (state_q[c])
          HOLD, REPEAT: begin
            if (dir == 2'b00) begin
              state_d[c] = IDLE;
              cnt_d[c]   = '0;
            end else begin
              cnt_d[c] = cnt_t;
              if (state_q[c] == HOLD && REPEAT_DELAY_MS != 0 && REPEAT_RATE_MS != 0 &&
                  ms_tick && cnt_t == CNTW'(REPEAT_DELAY_MS)) begin
                step_cw    = dir[0];
                step_ccw   = dir[1];
                cnt_d[c]   = '0;
                state_d[c] = REPEAT;
              end else if (state_q[c] == REPEAT && REPEAT_RATE_MS != 0 &&
                           ms_tick && cnt_t == CNTW'(REPEAT_RATE_MS)) begin
                step_cw  = dir[0];
                step_ccw = dir[1];
                cnt_d[c] = '0;
              end
            end
          end
          default: begin
            cnt_d[c] = '0;
`ifdef ROTARY_ABS_EN
            tgt = abs_target[c*IDXW +: IDXW];
            if (abs_valid[c] && dir == 2'b00 && REPEAT_RATE_MS != 0 &&
                int'(tgt) < POSITIONS && tgt != idx) begin
              cnt_d[c] = cnt_t;
              if (ms_tick && cnt_t == CNTW'(REPEAT_RATE_MS)) begin
                cnt_d[c] = '0;
                ccw_dist = (int'(tgt) >= int'(idx)) ? int'(tgt) - int'(idx)
                                                    : int'(tgt) + POSITIONS - int'(idx);
                // Ties (exactly half a turn) go clockwise.
                if (2 * ccw_dist < POSITIONS) step_ccw = 1'b1;
                else                          step_cw  = 1'b1;
              end
            end
`endif
          end
        endcase
      end
      if (step_cw)       idx = idx_dec(idx);
      else if (step_ccw) idx = idx_inc(idx);
      step_pulse_d[c]                      = step_cw | step_ccw;
      pos_idx_d[c*IDXW +: IDXW]            = idx;
      rotary_d[c*POSITIONS +: POSITIONS]   = POSITIONS'(1) << idx;
    end
  end

  // Single registered FSM/output bank with synchronous active-high reset.
  always_ff @(posedge clk_72) begin
    if (reset) begin
      presc_q      <= '0;
      pos_idx_q    <= {CHANNELS{IDXW'(RESET_POS)}};
      rotary_q     <= {CHANNELS{RESET_ONEHOT}};
      step_pulse_q <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c] <= IDLE;
        cnt_q[c]   <= '0;
        last_q[c]  <= 2'b00;
      end
    end else begin
      presc_q      <= presc_d;
      pos_idx_q    <= pos_idx_d;
      rotary_q     <= rotary_d;
      step_pulse_q <= step_pulse_d;
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c] <= state_d[c];
        cnt_q[c]   <= cnt_d[c];
        last_q[c]  <= last_d[c];
      end
    end
  end

  assign rotary     = rotary_q;
  assign pos_idx    = pos_idx_q;
  assign step_pulse = step_pulse_q;

endmodule

// File: doc/rotary_multi_ctrl.md
Name: rotary_multi_ctrl

Overview:
Multi-channel rotary-joystick emulator. Converts per-player clockwise/counter-clockwise button levels into one-hot rotary position vectors for the SNK68 game core. Generalised over channel count and number of positions. Adds hold-to-repeat with programmable delay and rate. Sits in the top level between arcade_inputs and the game core, on clk_72.

Parameters:
CHANNELS, 2, number of independent rotary channels.
POSITIONS, 12, positions per revolution (>=2); one-hot width per channel.
RESET_POS, 0, index of the asserted bit after reset.
CLK_HZ, 72000000, clk_72 frequency; millisecond tick period = CLK_HZ/1000 cycles.
REPEAT_DELAY_MS, 250, hold time (ms ticks) before the first auto-repeat step.
REPEAT_RATE_MS, 50, interval (ms ticks) between auto-repeat steps.

Ports:
clk_72  in  1  system clock.
reset  in  1  synchronous, active-high.
cw  in  CHANNELS  clockwise request level per channel, already in clk_72 domain.
ccw  in  CHANNELS  counter-clockwise request level per channel.
rotary  out  CHANNELS*POSITIONS  one-hot position per channel; channel c occupies bits [c*POSITIONS +: POSITIONS].
pos_idx  out  CHANNELS*IDXW  binary index of the asserted bit, IDXW=$clog2(POSITIONS).
step_pulse  out  CHANNELS  one-cycle strobe, registered with the position update.

Behaviour:
- Reset (synchronous, active-high; clock clk_72):
  - rotary = one-hot bit RESET_POS per channel; pos_idx = RESET_POS; step_pulse = 0.
  - All FSMs go to IDLE; the ms prescaler clears.
  - Last-sample registers clear to 0, so a button held through reset steps once on the first clock after reset deasserts.
  - Reset mid-repeat aborts the repeat immediately.
- Direction decode per channel:
  - CW = cw & ~ccw; CCW = ccw & ~cw.
  - Both high or both low = NEUTRAL, which never steps.
- CW step: index-1 mod POSITIONS. One-hot rotates toward the LSB: bit0 wraps to bit POSITIONS-1.
- CCW step: index+1 mod POSITIONS. Bit POSITIONS-1 wraps to bit0.
- Press event: the direction sampled this cycle is non-NEUTRAL and differs from the previous sample.
  - Step occurs at that same clock edge; the new rotary and step_pulse=1 are visible after the edge (latency 1 edge from input change).
- Prescaler: free-running counter, 0..CLK_HZ/1000-1. Emits ms_tick for one cycle at wrap. Shared by all channels.
- Per-channel FSM:
  - IDLE: on press event -> step, clear tick count, go HOLD.
  - HOLD: NEUTRAL -> IDLE. Direction change -> press event (step, restart HOLD). Count ms_ticks; when count reaches REPEAT_DELAY_MS -> step, clear count, go REPEAT.
  - REPEAT: NEUTRAL -> IDLE. Direction change -> press event, go HOLD. When count reaches REPEAT_RATE_MS -> step, clear count.
  - First-delay quantisation is up to one tick short, because the prescaler is not realigned on press.
- At most one step per channel per cycle.
- Channels are fully independent; simultaneous steps on different channels are allowed.
- REPEAT_DELAY_MS=0 or REPEAT_RATE_MS=0 disables auto-repeat: the FSM stays in HOLD, no further steps.
- Counters saturate; they never wrap back into a spurious step.

Optional Feature:
Macro ROTARY_ABS_EN.
- Defined:
  - Adds inputs abs_valid[CHANNELS] and abs_target[CHANNELS*IDXW].
  - While abs_valid=1 and the direction is NEUTRAL, the channel seeks the target: one step on each ms_tick interval of REPEAT_RATE_MS, along the shortest path; the first step follows one full interval.
  - Distance exactly POSITIONS/2 -> CW.
  - Stops when pos_idx==abs_target.
  - Targets >= POSITIONS are ignored.
  - cw/ccw activity has priority and resets the seek interval.
- Undefined: ports absent; behaviour exactly as above.

Test Plan:
- Reset with CHANNELS=2, POSITIONS=12 -> rotary=24'h001001, pos_idx=0/0, step_pulse=0.
- Ch0: cw high 1 cycle from reset state -> next edge rotary[11:0]=12'h800, pos_idx=11, one step_pulse; ccw pulse -> 12'h001. Ch1 unchanged throughout.
- cw and ccw both high 20 cycles -> no change, no step_pulse. Release ccw -> CW press event, one step on that edge.
- CLK_HZ=1000 (tick every cycle), REPEAT_DELAY_MS=3, REPEAT_RATE_MS=2; hold ccw 10 cycles -> steps at cycles 0, 3, 5, 7, 9. Index 0->5. Release -> no further steps.
- Hold cw through reset assertion -> no step during reset; one step on the first edge after release, then repeat timing restarts.
- ROTARY_ABS_EN: pos 0, abs_target=9, abs_valid=1 -> 3 CW steps (0->11->10->9), then stops. Target 6 from 0 -> CW tie rule, 6 steps.
